// File: rtl/bmp_pkg.sv
// Shared state encoding, BMP header constants and row/header helper functions
// for the BMP stream packer.
package bmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PIXEL,
        PAD,
        DONE
    } bmp_state_e;

    localparam int unsigned HDR_BYTES = 54;
    localparam int unsigned INFO_SIZE = 40;
    localparam int unsigned PPM       = 2835;

    function automatic int unsigned row_pad(input int unsigned w, input int unsigned bpp);
        return (4 - ((w * (bpp / 8)) % 4)) % 4;
    endfunction

    function automatic int unsigned row_stride(input int unsigned w, input int unsigned bpp);
        return w * (bpp / 8) + row_pad(w, bpp);
    endfunction

    // Whole header packed little-endian; file byte N lives in bits [8N+7:8N].
    function automatic logic [HDR_BYTES*8-1:0] hdr_rom(input int unsigned w,
                                                        input int unsigned h,
                                                        input int unsigned bpp);
        logic [HDR_BYTES*8-1:0] r;
        logic [31:0]            img;
        img          = 32'(row_stride(w, bpp) * h);
        r            = '0;
        r[15:0]      = 16'h4D42;
        r[2*8 +: 32] = img + 32'(HDR_BYTES);
        r[10*8 +: 32] = 32'(HDR_BYTES);
        r[14*8 +: 32] = 32'(INFO_SIZE);
        r[18*8 +: 32] = 32'(w);
        r[22*8 +: 32] = -32'(h);
        r[26*8 +: 16] = 16'd1;
        r[28*8 +: 16] = 16'(bpp);
        r[34*8 +: 32] = img;
        r[38*8 +: 32] = 32'(PPM);
        r[42*8 +: 32] = 32'(PPM);
        return r;
    endfunction

endpackage

// File: rtl/bmp_pix_fifo.sv
// Single-clock pixel FIFO with synchronous flush; a push while full is taken
// only when a pop happens in the same cycle.
module bmp_pix_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/bmp_stream_packer.sv
// Turns a DE/VS pixel stream into a byte stream of a top-down BMP file.
// Optional BMP_PACKER_LINE_CHECK_EN adds a per-line pixel count check (line_err).
module bmp_stream_packer
    import bmp_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BPP        = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vs_in,
    input  logic           hs_in,
    input  logic           de_in,
    input  logic [BPP-1:0] data_in,
    output logic [7:0]     byte_out,
    output logic           byte_valid,
    input  logic           byte_ready,
    output logic           sof,
    output logic           eof,
    output logic           overflow,
    output logic           frame_err,
    output logic           frame_done
`ifdef BMP_PACKER_LINE_CHECK_EN
    ,
    output logic           line_err
`endif
);
    localparam int unsigned BPB  = BPP / 8;
    localparam int unsigned PADN = row_pad(IMG_W, BPP);
    localparam bit          HAS_PAD = (PADN != 0);
    localparam logic [HDR_BYTES*8-1:0] HDR = hdr_rom(IMG_W, IMG_H, BPP);
    localparam logic [5:0]  LAST_HDR  = 6'(HDR_BYTES - 1);
    localparam logic [5:0]  LAST_PAD  = 6'(HAS_PAD ? PADN - 1 : 0);
    localparam logic [1:0]  LAST_BYTE = 2'(BPB - 1);
    localparam logic [11:0] LAST_COL  = 12'(IMG_W - 1);
    localparam logic [11:0] LAST_ROW  = 12'(IMG_H - 1);
    localparam logic [23:0] PIX_MAX   = 24'(IMG_W * IMG_H);

    bmp_state_e     r_state;
    bmp_state_e     w_next;
    logic [5:0]     r_cnt;
    logic [1:0]     r_bidx;
    logic [11:0]    r_col;
    logic [11:0]    r_row;
    logic [23:0]    r_pix_in;
    logic           r_vs_d;
    logic           r_ovf;
    logic           r_ferr;

    logic           w_vs_rise;
    logic           w_valid;
    logic           w_xfer;
    logic           w_pix_ok;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [BPP-1:0] w_head;
    logic [7:0]     w_hdr_byte;
    logic [7:0]     w_pix_byte;
    logic           w_row_end;
    logic           w_last_row;
    logic           w_pad_end;

    assign w_vs_rise  = vs_in && !r_vs_d;
    assign w_valid    = (r_state == HEADER) || (r_state == PAD) || (r_state == PIXEL && !w_empty);
    assign w_xfer     = w_valid && byte_ready;
    assign byte_valid = w_valid;
    assign overflow   = r_ovf;
    assign frame_err  = r_ferr;

    assign w_hdr_byte = 8'(HDR >> {r_cnt, 3'b000});
    assign w_pix_byte = 8'(w_head >> {r_bidx, 3'b000});
    assign w_row_end  = (r_col == LAST_COL) && (r_bidx == LAST_BYTE);
    assign w_last_row = (r_row == LAST_ROW);
    assign w_pad_end  = (r_cnt == LAST_PAD);

    // Pixels arriving with a frame-restarting VS edge belong to no frame and are dropped.
    assign w_pix_ok = de_in && !w_vs_rise && r_state != IDLE && r_state != DONE
                      && r_pix_in != PIX_MAX;
    assign w_pop    = w_xfer && r_state == PIXEL && r_bidx == LAST_BYTE;
    assign w_push   = w_pix_ok && (!w_full || w_pop);

    bmp_pix_fifo #(
        .WIDTH (BPP),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_vs_rise),
        .i_push  (w_push),
        .i_din   (data_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        byte_out   = 8'h00;
        sof        = 1'b0;
        eof        = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vs_rise) w_next = HEADER;
            end
            HEADER: begin
                byte_out = w_hdr_byte;
                sof      = (r_cnt == 6'd0);
                if (w_xfer && r_cnt == LAST_HDR) w_next = PIXEL;
            end
            PIXEL: begin
                byte_out = w_empty ? 8'h00 : w_pix_byte;
                eof      = !w_empty && w_row_end && w_last_row && !HAS_PAD;
                if (w_xfer && w_row_end) begin
                    if (HAS_PAD)         w_next = PAD;
                    else if (w_last_row) w_next = DONE;
                end
            end
            PAD: begin
                eof = w_last_row && w_pad_end;
                if (w_xfer && w_pad_end) w_next = w_last_row ? DONE : PIXEL;
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_vs_rise && r_state != IDLE) w_next = HEADER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bidx   <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_pix_in <= '0;
            r_vs_d   <= vs_in;
            r_ovf    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_vs_d <= vs_in;
            if (w_vs_rise) begin
                r_cnt    <= '0;
                r_bidx   <= '0;
                r_col    <= '0;
                r_row    <= '0;
                r_pix_in <= '0;
                if (r_state != IDLE) r_ferr <= 1'b1;
            end else begin
                if (w_pix_ok) r_pix_in <= r_pix_in + 24'd1;
                if (w_pix_ok && w_full && !w_pop) r_ovf <= 1'b1;
                if (w_xfer) begin
                    case (r_state)
                        HEADER: r_cnt <= (r_cnt == LAST_HDR) ? 6'd0 : r_cnt + 6'd1;
                        PIXEL: begin
                            if (r_bidx == LAST_BYTE) begin
                                r_bidx <= '0;
                                if (r_col == LAST_COL) begin
                                    r_col <= '0;
                                    if (!HAS_PAD) r_row <= r_row + 12'd1;
                                end else begin
                                    r_col <= r_col + 12'd1;
                                end
                            end else begin
                                r_bidx <= r_bidx + 2'd1;
                            end
                        end
                        PAD: begin
                            if (w_pad_end) begin
                                r_cnt <= '0;
                                r_row <= r_row + 12'd1;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef BMP_PACKER_LINE_CHECK_EN
    logic        r_hs_d;
    logic        r_line_err;
    logic [12:0] r_line_cnt;
    logic        w_in_frame;

    assign w_in_frame = r_state != IDLE && r_state != DONE;
    assign line_err   = r_line_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_d     <= 1'b0;
            r_line_err <= 1'b0;
            r_line_cnt <= '0;
        end else begin
            r_hs_d <= hs_in;
            if (w_vs_rise) begin
                r_line_cnt <= '0;
            end else if (w_in_frame && hs_in && !r_hs_d) begin
                // An HS edge with no pixels since the previous one is a blanking line.
                if (r_line_cnt != 13'd0 && r_line_cnt != 13'(IMG_W)) r_line_err <= 1'b1;
                r_line_cnt <= {12'd0, de_in};
            end else if (w_in_frame && de_in) begin
                r_line_cnt <= r_line_cnt + 13'd1;
            end
        end
    end
`else
    logic w_unused_hs;
    assign w_unused_hs = hs_in;
`endif

endmodule

// File: tb/tb_bmp_stream_packer.sv
// Directed-random bench for bmp_stream_packer: three differently sized instances
// checked against a byte-level BMP file model built from the format rules.
module tb_bmp_stream_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       vs   = '0;
    logic [2:0]       hs   = '0;
    logic [2:0]       de   = '0;
    logic [2:0]       rdy  = '0;
    logic [2:0][31:0] data = '0;
    logic [2:0][7:0]  bo;
    logic [2:0]       bv, sofo, eofo, ovf, ferr, fdone;
`ifdef BMP_PACKER_LINE_CHECK_EN
    logic [2:0]       lerr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] pix_q[$];

    // A: 3x2x24 (row padding), B: 2x1x32 (no padding), C: 4x8x24 (overflow / abort)
    bmp_stream_packer #(.IMG_W(3), .IMG_H(2), .BPP(24), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .vs_in(vs[0]), .hs_in(hs[0]), .de_in(de[0]),
        .data_in(data[0][23:0]), .byte_out(bo[0]), .byte_valid(bv[0]), .byte_ready(rdy[0]),
        .sof(sofo[0]), .eof(eofo[0]), .overflow(ovf[0]), .frame_err(ferr[0]),
        .frame_done(fdone[0])
`ifdef BMP_PACKER_LINE_CHECK_EN
        , .line_err(lerr[0])
`endif
    );

    bmp_stream_packer #(.IMG_W(2), .IMG_H(1), .BPP(32), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .vs_in(vs[1]), .hs_in(hs[1]), .de_in(de[1]),
        .data_in(data[1]), .byte_out(bo[1]), .byte_valid(bv[1]), .byte_ready(rdy[1]),
        .sof(sofo[1]), .eof(eofo[1]), .overflow(ovf[1]), .frame_err(ferr[1]),
        .frame_done(fdone[1])
`ifdef BMP_PACKER_LINE_CHECK_EN
        , .line_err(lerr[1])
`endif
    );

    bmp_stream_packer #(.IMG_W(4), .IMG_H(8), .BPP(24), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .vs_in(vs[2]), .hs_in(hs[2]), .de_in(de[2]),
        .data_in(data[2][23:0]), .byte_out(bo[2]), .byte_valid(bv[2]), .byte_ready(rdy[2]),
        .sof(sofo[2]), .eof(eofo[2]), .overflow(ovf[2]), .frame_err(ferr[2]),
        .frame_done(fdone[2])
`ifdef BMP_PACKER_LINE_CHECK_EN
        , .line_err(lerr[2])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_le(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(v >> (8 * i)));
    endtask

    // Reference BMP file from the format rules; missing pixels read as zero.
    task automatic build_file(input int w, input int h, input int bpp);
        int bpb, pad, stride;
        bpb    = bpp / 8;
        pad    = (4 - (w * bpb) % 4) % 4;
        stride = w * bpb + pad;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        put_le(32'(54 + stride * h), 4);
        put_le(0, 4);
        put_le(54, 4);
        put_le(40, 4);
        put_le(32'(w), 4);
        put_le(32'(-h), 4);
        put_le(1, 2);
        put_le(32'(bpp), 2);
        put_le(0, 4);
        put_le(32'(stride * h), 4);
        put_le(2835, 4);
        put_le(2835, 4);
        put_le(0, 4);
        put_le(0, 4);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++)
                put_le((r * w + c < pix_q.size()) ? pix_q[r * w + c] : 32'h0, bpb);
            for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vs  = '0;
        hs  = '0;
        de  = '0;
        rdy = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Starts a frame on instance d and checks every transferred byte until stop_at bytes.
    task automatic run_frame(input int d, input bit rnd, input int stop_at, input int max_cyc);
        int         idx, pi, cyc;
        bit         stalled;
        logic [9:0] cur, prev;
        idx = 0; pi = 0; cyc = 0; stalled = 1'b0; prev = '0;
        got_q.delete();
        vs[d] = 1'b1;
        @(negedge clk);
        chk("sof_latency", {bv[d], sofo[d], bo[d]}, {2'b11, 8'h42});
        vs[d] = 1'b0;
        while (idx < stop_at && cyc < max_cyc) begin
            rdy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pi < pix_q.size() && $urandom_range(0, 3) != 0) begin
                de[d]   = 1'b1;
                data[d] = pix_q[pi];
                pi++;
            end else begin
                de[d] = 1'b0;
            end
            #1;
            cur = {sofo[d], eofo[d], bo[d]};
            if (stalled) chk("stall_hold", cur, prev);
            if (bv[d] && rdy[d]) begin
                chk($sformatf("byte%0d", idx), cur,
                    {idx == 0, idx == exp_q.size() - 1, exp_q[idx]});
                got_q.push_back(bo[d]);
                idx++;
            end
            stalled = bv[d] && !rdy[d];
            prev    = cur;
            @(negedge clk);
            cyc++;
        end
        de[d]  = 1'b0;
        rdy[d] = 1'b0;
        chk("frame_bytes", 64'(idx), 64'(stop_at));
        if (stop_at == exp_q.size()) chk("frame_done", fdone[d], 1'b1);
    endtask

    initial begin
        int idx;

        // Reset state on all three instances
        do_reset();
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_outs%0d", d),
                {bo[d], bv[d], sofo[d], eofo[d], fdone[d], ovf[d], ferr[d]}, '0);

        // A: 3x2x24, always ready
        pix_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back($urandom & 32'h00FF_FFFF);
        build_file(3, 2, 24);
        run_frame(0, 1'b0, 78, 400);
        if (got_q.size() == 78) begin
            chk("a_bfsize", {got_q[5], got_q[4], got_q[3], got_q[2]}, 32'h0000_004E);
            chk("a_height", {got_q[25], got_q[24], got_q[23], got_q[22]}, 32'hFFFF_FFFE);
            chk("a_pad_row0", {got_q[63], got_q[64], got_q[65]}, 24'h0);
            chk("a_pad_row1", {got_q[75], got_q[76], got_q[77]}, 24'h0);
        end
        chk("a_flags", {ovf[0], ferr[0]}, 2'b00);
        repeat (2) @(negedge clk);

        // A again with random backpressure: same pixels, same file
        run_frame(0, 1'b1, 78, 2000);
        chk("a_rnd_flags", {ovf[0], ferr[0]}, 2'b00);

        // B: 2x1x32, no row padding
        pix_q.delete();
        pix_q.push_back(32'h1122_3344);
        pix_q.push_back($urandom);
        build_file(2, 1, 32);
        run_frame(1, 1'b0, 62, 400);
        if (got_q.size() == 62) begin
            chk("b_bitcount", got_q[28], 8'h20);
            chk("b_pix0", {got_q[54], got_q[55], got_q[56], got_q[57]}, 32'h4433_2211);
        end

        // C: 24 pixels into a 16-deep FIFO while the sink is stalled
        do_reset();
        pix_q.delete();
        for (int i = 0; i < 24; i++) pix_q.push_back($urandom & 32'h00FF_FFFF);
        build_file(4, 8, 24);
        vs[2] = 1'b1;
        @(negedge clk);
        vs[2] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            de[2] = (i < 24);
            if (i < 24) data[2] = pix_q[i];
            @(negedge clk);
        end
        de[2] = 1'b0;
        chk("ovf_set", ovf[2], 1'b1);
        chk("ovf_hdr_hold", {bv[2], sofo[2], bo[2]}, {2'b11, 8'h42});
        rdy[2] = 1'b1;
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (bv[2] && idx < exp_q.size()) begin
                chk($sformatf("ovf_byte%0d", idx), {eofo[2], bo[2]}, {1'b0, exp_q[idx]});
                idx++;
            end
            @(negedge clk);
        end
        chk("ovf_bytes_out", 64'(idx), 64'd102);
        chk("ovf_drained", bv[2], 1'b0);
        chk("ovf_sticky", ovf[2], 1'b1);

        // C: VS restart after two rows of four pixels
        do_reset();
        pix_q.delete();
        for (int i = 0; i < 8; i++) pix_q.push_back($urandom & 32'h00FF_FFFF);
        build_file(4, 8, 24);
        run_frame(2, 1'b0, 78, 400);
        chk("pre_abort_ferr", ferr[2], 1'b0);
        vs[2] = 1'b1;
        @(negedge clk);
        vs[2] = 1'b0;
        chk("abort_ferr", ferr[2], 1'b1);
        chk("abort_restart", {bv[2], sofo[2], eofo[2], bo[2]}, {3'b110, 8'h42});

        // Reset in the middle of a header abandons the file
        do_reset();
        chk("reset_midframe", {bv[2], ferr[2], ovf[2]}, 3'b000);

`ifdef BMP_PACKER_LINE_CHECK_EN
        chk("lerr_reset", lerr[2], 1'b0);
        vs[2] = 1'b1;
        @(negedge clk);
        vs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            de[2] = 1'b1;
            @(negedge clk);
        end
        de[2] = 1'b0;
        @(negedge clk);
        chk("lerr_before_hs", lerr[2], 1'b0);
        hs[2] = 1'b1;
        @(negedge clk);
        hs[2] = 1'b0;
        @(negedge clk);
        chk("lerr_set", lerr[2], 1'b1);
        repeat (5) @(negedge clk);
        chk("lerr_hold", lerr[2], 1'b1);
        do_reset();
        chk("lerr_clear", lerr[2], 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bmp_stream_packer.md
BMP_STREAM_PACKER -- requirements
Module: bmp_stream_packer

Interface
REQ-001 Parameters, SHALL be: IMG_W, default 640, pixels per line (1..4095).
REQ-002 Parameter SHALL be: IMG_H, default 480, lines per frame (1..4095).
REQ-003 Parameter SHALL be: BPP, default 24, bits per pixel; legal values 24 or 32.
REQ-004 Parameter SHALL be: FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, >= 4).
REQ-005 Ports SHALL be: clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 vs_in  in  1  vertical sync; rising edge marks frame start.
REQ-008 hs_in  in  1  horizontal sync; used only by line check (REQ-027).
REQ-009 de_in  in  1  pixel valid, one pixel per cycle, no backpressure.
REQ-010 data_in  in  BPP  pixel, [7:0]=B, [15:8]=G, [23:16]=R, [31:24]=A when BPP=32.
REQ-011 byte_out  out  8  BMP file byte stream.
REQ-012 byte_valid  out  1  byte_out valid.
REQ-013 byte_ready  in  1  downstream accepts byte when byte_valid & byte_ready.
REQ-014 sof / eof  out  1 each  qualify first header byte / last byte of file.
REQ-015 overflow / frame_err  out  1 each  sticky error flags.
REQ-016 frame_done  out  1  one-cycle pulse after the eof byte transfers.

Function
REQ-017 Output SHALL be a complete top-down BMP file: 54-byte header, then IMG_H rows, each IMG_W pixels of BPP/8 bytes, LSB first, followed by PAD = (4 - (IMG_W*BPP/8) mod 4) mod 4 zero bytes.
REQ-018 Header SHALL be little-endian: "BM" (0x42,0x4D); bfSize = 54 + STRIDE*IMG_H, where STRIDE = IMG_W*BPP/8 + PAD; reserved 0; bfOffBits 54; biSize 40; biWidth IMG_W; biHeight = -IMG_H (two's complement); biPlanes 1; biBitCount BPP; biCompression 0; biSizeImage STRIDE*IMG_H; X/YPelsPerMeter 2835; ClrUsed/ClrImportant 0.
REQ-019 FSM states: IDLE, HEADER, PIXEL, PAD, DONE. IDLE->HEADER on vs_in rising edge; HEADER->PIXEL after byte 53 transfers; PIXEL->PAD after the last byte of each row when PAD>0 (else stay in PIXEL, or go to DONE); PAD->PIXEL after PAD bytes; last row's final byte -> DONE; DONE->IDLE next cycle, pulsing frame_done.
REQ-020 A byte SHALL transfer only on byte_valid & byte_ready; byte_out, sof and eof SHALL hold stable while byte_valid & !byte_ready.
REQ-021 Pixels with de_in=1 SHALL be written to the FIFO in any state except IDLE and DONE, up to IMG_W*IMG_H per frame; excess pixels SHALL be discarded silently.
REQ-022 byte_valid SHALL be 1 in HEADER and PAD unconditionally, and in PIXEL only when the FIFO is non-empty; a FIFO entry SHALL pop when its last byte transfers.
REQ-023 FIFO full with de_in=1 SHALL drop the pixel and set overflow; a simultaneous pop and push on full SHALL succeed without overflow.
REQ-024 A vs_in rising edge outside IDLE SHALL set frame_err, flush the FIFO, drop the current file without asserting eof, and enter HEADER for the new frame.
REQ-025 Latency: first header byte (sof) SHALL be valid the cycle after the vs_in rising edge is sampled.

Reset
REQ-026 With rst=1: state IDLE, FIFO empty, counters 0, byte_out=0, byte_valid=0, sof=0, eof=0, frame_done=0, overflow=0, frame_err=0. Reset mid-frame SHALL abandon the file with no further output.

Configuration
REQ-027 Macro BMP_PACKER_LINE_CHECK_EN defined: each hs_in rising edge inside a frame SHALL compare the line's de_in count against IMG_W and, on mismatch, set sticky output line_err (port present only with the macro). Macro undefined: port and logic absent, hs_in unused.

Structure
REQ-028 Package bmp_pkg SHALL hold the state enum, header-offset constants (HDR_BYTES=54, INFO_SIZE=40, PPM=2835) and a constant function computing PAD/STRIDE.
REQ-029 The pixel FIFO SHALL be a sub-module bmp_pix_fifo (width BPP, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-030 IMG_W=3, IMG_H=2, BPP=24, byte_ready=1: 78 bytes total; bytes 2..5 = 4E 00 00 00; bytes 22..25 = FE FF FF FF; 3 zero pad bytes after each 9-byte row; eof on byte 77.
REQ-031 BPP=32, IMG_W=2, IMG_H=1: no pad; byte 28 = 0x20; pixel 0x11223344 emitted as 44 33 22 11.
REQ-032 byte_ready toggled randomly (50%): byte_out/sof/eof stable across stalls; stream identical to REQ-030.
REQ-033 byte_ready=0 for 40 cycles while 24 pixels arrive, FIFO_DEPTH=16: overflow=1, 8 pixels dropped.
REQ-034 Second vs_in rise after 2 rows of 4: frame_err=1, no eof, next byte_out = 0x42 with sof=1.
REQ-035 With BMP_PACKER_LINE_CHECK_EN defined, a line of IMG_W-1 pixels followed by hs_in rise: line_err=1, held until rst.
